// File: rtl/alu_result_collector.sv
// Captures my_alu's registered result one cycle after issue, tags it with the issued opcode,
// and queues it in a DEPTH-entry FIFO for a valid/ready consumer, with saturating event counters.
module alu_result_collector #(
    parameter int NUMBITS = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [2:0]               issue_opcode,
    input  logic [NUMBITS-1:0]       alu_result,
    input  logic                     alu_carryout,
    input  logic                     alu_overflow,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUMBITS-1:0]       out_result,
    output logic [2:0]               out_opcode,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic [CNT_W-1:0]         carry_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     drop_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [2:0]         op;
        logic               carry;
        logic               ovf;
        logic               zero;
        logic [NUMBITS-1:0] res;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          cap_entry;
    logic            cap_v;
    logic [2:0]      cap_op;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            pop, push, drop;

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    // A full FIFO can still take the capture when the head leaves this same cycle.
    assign push       = cap_v && ((count != DEPTH_C) || pop);
    assign drop       = cap_v && !push;
    assign cap_entry  = '{op: cap_op, carry: alu_carryout, ovf: alu_overflow,
                          zero: alu_zero, res: alu_result};

    assign head       = mem[rd_ptr];
    assign out_result = out_valid ? head.res : '0;
    assign out_opcode = out_valid ? head.op  : '0;
    assign out_flags  = out_valid ? {head.carry, head.ovf, head.zero} : '0;
    assign fifo_count = count;
    assign full       = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cap_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_v       <= 1'b0;
            cap_op      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            carry_cnt   <= '0;
            ovf_cnt     <= '0;
            drop_cnt    <= '0;
            drop_sticky <= 1'b0;
        end else begin
            cap_v  <= issue_valid;
            cap_op <= issue_opcode;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push && alu_carryout && carry_cnt != CNT_MAX) carry_cnt <= carry_cnt + 1'b1;
            if (push && alu_overflow && ovf_cnt != CNT_MAX)   ovf_cnt   <= ovf_cnt + 1'b1;
            if (drop) begin
                drop_sticky <= 1'b1;
                if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector, checked every cycle against a
// queue-based reference model; includes a small registered ALU standing in for my_alu.
module tb_alu_result_collector;
    localparam int NUMBITS = 32;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                issue_valid = 1'b0;
    logic [2:0]          issue_opcode = '0;
    logic [31:0]         a = '0, b = '0;
    logic [NUMBITS-1:0]  alu_result = '0;
    logic                alu_carryout = 1'b0, alu_overflow = 1'b0, alu_zero = 1'b0;
    logic                out_valid, out_ready = 1'b0;
    logic [NUMBITS-1:0]  out_result;
    logic [2:0]          out_opcode, out_flags;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                full, drop_sticky;
    logic [CNT_W-1:0]    carry_cnt, ovf_cnt, drop_cnt;

    int n_vec = 0, n_err = 0;

    alu_result_collector #(.NUMBITS(NUMBITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_flags(out_flags),
        .fifo_count(fifo_count), .full(full), .carry_cnt(carry_cnt), .ovf_cnt(ovf_cnt),
        .drop_cnt(drop_cnt), .drop_sticky(drop_sticky));

    always #5 clk = ~clk;

    // Stand-in for my_alu: registered result; opcode 0 is add, others subtract with random flags
    logic [32:0] sum;
    always @(posedge clk) begin
        if (issue_opcode == 3'd0) begin
            sum = {1'b0, a} + {1'b0, b};
            alu_result   <= sum[31:0];
            alu_carryout <= sum[32];
            alu_overflow <= (a[31] == b[31]) && (sum[31] != a[31]);
            alu_zero     <= (sum[31:0] == 32'd0);
        end else begin
            alu_result   <= a - b;
            alu_carryout <= 1'($urandom % 2);
            alu_overflow <= 1'($urandom % 2);
            alu_zero     <= 1'($urandom % 2);
        end
    end

    // Reference model: ordered queue plus plain integer counters
    typedef struct { logic [31:0] res; logic [2:0] op; logic [2:0] flags; } ent_t;
    ent_t q[$];
    ent_t e;
    bit   m_cap_v = 0;
    logic [2:0] m_cap_op = '0;
    int   m_carry = 0, m_ovf = 0, m_drop = 0;
    bit   m_sticky = 0, started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            q.delete();
            m_cap_v = 0; m_cap_op = '0;
            m_carry = 0; m_ovf = 0; m_drop = 0; m_sticky = 0;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (m_cap_v) begin
                if (q.size() < DEPTH) begin
                    e.res = alu_result; e.op = m_cap_op;
                    e.flags = {alu_carryout, alu_overflow, alu_zero};
                    q.push_back(e);
                    if (alu_carryout) m_carry = (m_carry < CMAX) ? m_carry + 1 : CMAX;
                    if (alu_overflow) m_ovf   = (m_ovf   < CMAX) ? m_ovf + 1   : CMAX;
                end else begin
                    m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
                    m_sticky = 1;
                end
            end
            m_cap_v = issue_valid;
            m_cap_op = issue_opcode;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("fifo_count", 64'(fifo_count), 64'(q.size()));
            check("full", 64'(full), 64'(q.size() == DEPTH));
            check("carry_cnt", 64'(carry_cnt), 64'(m_carry));
            check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            check("drop_sticky", 64'(drop_sticky), 64'(m_sticky));
            if (q.size() != 0) begin
                check("out_result", 64'(out_result), 64'(q[0].res));
                check("out_opcode", 64'(out_opcode), 64'(q[0].op));
                check("out_flags", 64'(out_flags), 64'(q[0].flags));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        issue_valid = 1'b1; issue_opcode = op; a = av; b = bv;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);

        // Single op: 5 + 7
        issue(3'd0, 32'd5, 32'd7);
        check("lat_n1_valid", 64'(out_valid), 64'd0);
        tick();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_result", 64'(out_result), 64'd12);
        check("single_opcode", 64'(out_opcode), 64'd0);
        check("single_flags", 64'(out_flags), 64'b000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("single_popped", 64'(fifo_count), 64'd0);

        // Carry: FFFFFFFF + 1
        issue(3'd0, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("carry_result", 64'(out_result), 64'd0);
        check("carry_flags", 64'(out_flags), 64'b101);
        check("carry_cnt_lit", 64'(carry_cnt), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Fill/drop: 10 back-to-back issues with consumer stalled
        for (int i = 0; i < 10; i++) issue(3'd0, 32'(i * 16), 32'd1);
        tick();
        check("fill_count", 64'(fifo_count), 64'd8);
        check("fill_full", 64'(full), 64'd1);
        check("fill_drop", 64'(drop_cnt), 64'd2);
        check("fill_sticky", 64'(drop_sticky), 64'd1);
        check("fill_head", 64'(out_result), 64'd1);

        // Full with simultaneous pop: capture accepted
        issue(3'd0, 32'd100, 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("fullpop_count", 64'(fifo_count), 64'd8);
        check("fullpop_drop", 64'(drop_cnt), 64'd2);

        out_ready = 1'b1; tick(10);
        check("drain_count", 64'(fifo_count), 64'd0);

        // Wrap-around: 20 issues with the consumer always ready
        for (int i = 0; i < 20; i++) issue(3'(i % 8), 32'(i * 3), 32'd2);
        tick(2);
        check("wrap_count", 64'(fifo_count), 64'd0);
        check("wrap_drop", 64'(drop_cnt), 64'd2);

        // Reset mid-operation: 3 queued plus one in the capture stage
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(3'd0, 32'hFFFF_FFFF, 32'(i + 1));
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_count", 64'(fifo_count), 64'd0);
        check("rst_mid_carry", 64'(carry_cnt), 64'd0);
        check("rst_mid_drop", 64'(drop_cnt), 64'd0);
        check("rst_mid_sticky", 64'(drop_sticky), 64'd0);
        tick(3);
        check("rst_mid_no_stale", 64'(fifo_count), 64'd0);

        // Random traffic; second half stalls the consumer so counters saturate
        for (int c = 0; c < 3000; c++) begin
            int sel;
            issue_valid  = ($urandom % 10) < 7;
            issue_opcode = ($urandom % 2) ? 3'd0 : 3'($urandom_range(1, 7));
            sel = $urandom % 8;
            a = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h7FFF_FFFF : $urandom;
            b = (sel == 0) ? 32'd1 : (sel == 1) ? 32'd1 : (sel == 2) ? (~a + 1) : $urandom;
            out_ready = (c < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            reset = (c < 1500) && (($urandom % 300) == 0);
            tick();
        end
        reset = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
        tick(12);
        check("final_count", 64'(fifo_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
